prog_load_ctrl: RTL
===================

Name: prog_load_ctrl

Overview:
- Program-load and run sequencer for the 8-bit accumulator core.
- Accepts a framed byte stream from the host: length byte, L program bytes, then an XOR checksum byte.
- Writes the program bytes into the core's instruction memory over the existing write-enable/address/data path, holding the core in reset meanwhile.
- Releases the core only on a valid frame, then supervises it until it halts or a watchdog expires.

Parameters:
- ADDR_W, 5, instruction-memory address width.
- DEPTH, 19, number of instruction-memory entries; maximum legal L.
- MAX_CYCLES, 1024, watchdog limit on cycles spent in RUN; must be ≥2.
- CNT_W, 16, width of run_cycles; must hold MAX_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured in IDLE, DONE, ERROR only.
- abort  in  1  return to IDLE from any state.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  controller accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_rst  out  1  active-high hold-in-reset to the core.
- cpu_halted  in  1  core has executed HALT.
- status  out  3  current state code.
- err_code  out  2  0 none, 1 BADLEN, 2 BADSUM, 3 TIMEOUT.
- run_cycles  out  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, status=0, err_code=0, run_cycles=0. Reset mid-load or mid-run behaves the same; partially written memory is not cleared.
- All outputs are registered. Handshake: a byte is accepted when in_valid & in_ready at the clock edge. in_valid while in_ready=0 is ignored; the byte is dropped and no error is flagged.
- State codes: IDLE=0, LEN=1, LOAD=2, CHECK=3, RUN=4, DONE=5, ERROR=6.
- in_ready=1 exactly in LEN, LOAD and CHECK. Throughput is one byte per cycle.
- IDLE: cpu_rst=1. start -> LEN.
- DONE/ERROR + start -> LEN; on entry err_code=0, run_cycles=0, cpu_rst=1.
- start in any other state is ignored.
- LEN: on accept, L=in_data.
  - L==0 or L>DEPTH -> ERROR, err_code=1.
  - Otherwise latch L, clear checksum and write pointer -> LOAD.
- LOAD: byte k (k=0..L-1) on accept:
  - Next cycle: mem_we=1 for exactly one cycle, mem_addr=k, mem_wdata=byte.
  - csum ^= byte; pointer increments.
  - After byte L-1 is accepted -> CHECK. The write of the last byte occurs in the first CHECK cycle.
  - mem_we is otherwise 0 in every state. Pointer never wraps, since L≤DEPTH.
- CHECK: on accept:
  - in_data==csum -> RUN; cpu_rst=0 from the first RUN cycle; run_cycles=0.
  - Otherwise -> ERROR, err_code=2, cpu_rst stays 1.
- RUN: run_cycles increments every cycle.
  - cpu_halted=1 -> DONE. cpu_rst stays 0 so the core's accumulator output remains visible; run_cycles freezes.
  - run_cycles==MAX_CYCLES-1 without halt -> ERROR, err_code=3, cpu_rst=1 next cycle.
  - Halt and timeout in the same cycle: halt wins (DONE).
- abort (priority over start and the handshake; lower than rst): any state -> IDLE next cycle. cpu_rst=1, in_ready=0, err_code=0; a pending mem_we is suppressed.
- status always reflects the registered state.

Test Plan:
- Good load: start; bytes 03, 01, 05, 0A, csum 0E -> mem writes (0,01), (1,05), (2,0A) on consecutive cycles; status 1→2→3→4; cpu_rst falls in the first RUN cycle; cpu_halted after 8 cycles -> status 5, run_cycles=8, err_code=0.
- Bad checksum: same frame with csum 0F -> three writes occur, status 6, err_code=2, cpu_rst stays 1; then start plus a good frame -> RUN.
- Bad length: L=00 and separately L=20 (>19) -> ERROR, err_code=1, no mem_we pulse.
- Watchdog: good frame, cpu_halted held 0 -> ERROR after exactly MAX_CYCLES RUN cycles, err_code=3, cpu_rst=1. Repeat with cpu_halted rising on the final cycle -> DONE.
- Flow control: in_valid toggled with gaps during LOAD, plus in_valid asserted in IDLE -> IDLE bytes ignored; writes occur only for accepted bytes, with contiguous addresses.
- Abort/reset: abort mid-LOAD after 2 of 5 bytes -> IDLE, no further writes, cpu_rst=1. rst during RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// Program-load and run sequencer for the 8-bit accumulator core.
// Receives a framed byte stream (length, program bytes, XOR checksum),
// writes the program into instruction memory while holding the core in
// reset, then releases and supervises the core until HALT or watchdog.
module prog_load_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 19,
    parameter int MAX_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halted,
    output logic [2:0]        status,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [7:0]       DEPTH_B  = 8'(DEPTH);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t            state_q, state_n;
    logic [7:0]        len_q, len_n;
    logic [7:0]        csum_q, csum_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;

    logic              in_ready_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;
    logic              cpu_rst_n;
    logic [1:0]        err_n;
    logic [CNT_W-1:0]  run_n;
    logic              accept;

    assign accept = in_valid & in_ready;
    assign status = state_q;

    // State and registered-output update; memory contents are never cleared here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            ptr_q      <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst    <= 1'b1;
            err_code   <= 2'd0;
            run_cycles <= '0;
        end else begin
            state_q    <= state_n;
            len_q      <= len_n;
            csum_q     <= csum_n;
            ptr_q      <= ptr_n;
            in_ready   <= in_ready_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            cpu_rst    <= cpu_rst_n;
            err_code   <= err_n;
            run_cycles <= run_n;
        end
    end

    // Next-state and next-output decode; abort overrides start and the handshake.
    always_comb begin
        state_n     = state_q;
        len_n       = len_q;
        csum_n      = csum_q;
        ptr_n       = ptr_q;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        err_n       = err_code;
        run_n       = run_cycles;

        if (abort) begin
            state_n = S_IDLE;
            err_n   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_LEN;
                        run_n   = '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (in_data == 8'd0 || in_data > DEPTH_B) begin
                            state_n = S_ERROR;
                            err_n   = 2'd1;
                        end else begin
                            len_n   = in_data;
                            csum_n  = 8'd0;
                            ptr_n   = '0;
                            state_n = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = ptr_q;
                        mem_wdata_n = in_data;
                        csum_n      = csum_q ^ in_data;
                        ptr_n       = ptr_q + ADDR_W'(1);
                        if (8'(ptr_q) == len_q - 8'd1) begin
                            state_n = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (in_data == csum_q) begin
                            state_n = S_RUN;
                            run_n   = '0;
                        end else begin
                            state_n = S_ERROR;
                            err_n   = 2'd2;
                        end
                    end
                end
                S_RUN: begin
                    // The leaving edge is counted too, so run_cycles equals RUN cycles spent.
                    run_n = run_cycles + CNT_W'(1);
                    if (cpu_halted) begin
                        state_n = S_DONE;
                    end else if (run_cycles == RUN_LAST) begin
                        state_n = S_ERROR;
                        err_n   = 2'd3;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state_n = S_LEN;
                        err_n   = 2'd0;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        in_ready_n = (state_n == S_LEN) || (state_n == S_LOAD) || (state_n == S_CHECK);
        // Core stays released in DONE so its accumulator output remains observable.
        cpu_rst_n  = !((state_n == S_RUN) || (state_n == S_DONE));
    end

endmodule
